// File: rtl/adc_spi_pkg.sv
// Shared definitions for the ADC SPI link.
// Both the responder and the ADC controller import this package.
package adc_spi_pkg;

  localparam int ADC_DATA_W      = 12;
  localparam int ADC_CFG_W       = 6;
  localparam int ADC_CONV_CYCLES = 80;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SHIFT   = 2'd2
  } resp_state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin.
// Adds an edge register that produces registered one-cycle rise and fall pulses.
// A pin edge reaches rise_o/fall_o three clk cycles later.
module spi_pin_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic rise_q;
  logic fall_q;

  // Synchronizer chain, previous-level register and registered edge pulses.
  // NOTE: every flop in a clocked block uses <= so all stages sample the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= pin_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
      fall_q <= ~sync_q & prev_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/adc_spi_responder.sv
// SPI ADC slave model: latches sample_in on a convst rise and holds busy for CONV_CYCLES.
// It then shifts the sample out MSB-first on adc_sdo, updating after each sck fall.
// Optional macro ADC_RESP_CFG_EN enables capture of the LSB-first config word from adc_sdi.
// Without the macro, adc_sdi is ignored and cfg_out/cfg_valid are tied to 0.
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int DATA_W      = ADC_DATA_W,
  parameter int CFG_W       = ADC_CFG_W,
  parameter int CONV_CYCLES = ADC_CONV_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              adc_convst,
  input  logic              adc_sck,
  input  logic              adc_sdi,
  output logic              adc_sdo,
  input  logic [DATA_W-1:0] sample_in,
  output logic              busy,
  output logic [CFG_W-1:0]  cfg_out,
  output logic              cfg_valid,
  output logic              frame_done
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam int CNT_W = $clog2(CONV_CYCLES + 1);

  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CONV_LOAD = CNT_W'(CONV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  resp_state_t       state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [BIT_W-1:0]  bitcnt_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              sdo_q;
  logic              frame_done_q;

  logic       convst_rise;
  logic       sck_fall;
  logic [3:0] unused_sync;

  spi_pin_sync u_convst_sync (
    .clk     (clk),
    .rst_n   (reset),
    .pin_i   (adc_convst),
    .level_o (unused_sync[0]),
    .rise_o  (convst_rise),
    .fall_o  (unused_sync[1])
  );

  spi_pin_sync u_sck_sync (
    .clk     (clk),
    .rst_n   (reset),
    .pin_i   (adc_sck),
    .level_o (unused_sync[2]),
    .rise_o  (unused_sync[3]),
    .fall_o  (sck_fall)
  );

  // A convst rise outranks an sck fall in the same cycle, so a shift step only
  // happens when no restart is pending.
  logic shift_fall;
  logic frame_end;

  assign shift_fall = (state_q == SHIFT) && sck_fall && !convst_rise;
  assign frame_end  = shift_fall && (bitcnt_q == LAST_BIT);

  // Responder FSM with registered busy, sdo and frame_done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      sdo_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (convst_rise) begin
            shreg_q <= sample_in;
            cnt_q   <= CONV_LOAD;
            busy_q  <= 1'b1;
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          // A second convst rise is ignored here; the counter runs on.
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_ONE) begin
            busy_q   <= 1'b0;
            sdo_q    <= shreg_q[DATA_W-1];
            bitcnt_q <= '0;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          if (convst_rise) begin
            // Abort the current frame and start a fresh conversion.
            shreg_q <= sample_in;
            cnt_q   <= CONV_LOAD;
            busy_q  <= 1'b1;
            sdo_q   <= 1'b0;
            state_q <= CONVERT;
          end else if (shift_fall) begin
            shreg_q <= {shreg_q[DATA_W-2:0], 1'b0};
            if (frame_end) begin
              sdo_q        <= 1'b0;
              bitcnt_q     <= '0;
              frame_done_q <= 1'b1;
              state_q      <= IDLE;
            end else begin
              sdo_q    <= shreg_q[DATA_W-2];
              bitcnt_q <= bitcnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign adc_sdo    = sdo_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

`ifdef ADC_RESP_CFG_EN
  logic             sdi_sync;
  logic [1:0]       unused_sdi_edges;
  logic             frame_start;
  logic [CFG_W-1:0] cfg_shadow_q;
  logic [CFG_W-1:0] cfg_shadow_d;
  logic [CFG_W-1:0] cfg_out_q;
  logic             cfg_valid_q;

  spi_pin_sync u_sdi_sync (
    .clk     (clk),
    .rst_n   (reset),
    .pin_i   (adc_sdi),
    .level_o (sdi_sync),
    .rise_o  (unused_sdi_edges[0]),
    .fall_o  (unused_sdi_edges[1])
  );

  // Every accepted convst rise begins a new frame with a clean shadow.
  assign frame_start = convst_rise && (state_q != CONVERT);

  // Next shadow value: clear on frame start, else drop sdi into bit [bitcnt].
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    cfg_shadow_d = cfg_shadow_q;
    if (frame_start) begin
      cfg_shadow_d = '0;
    end else if (shift_fall) begin
      for (int i = 0; i < CFG_W; i++) begin
        if (bitcnt_q == BIT_W'(i)) cfg_shadow_d[i] = sdi_sync;
      end
    end
  end

  // Shadow register and commit of the full word at the end of a complete frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_shadow_q <= '0;
      cfg_out_q    <= '0;
      cfg_valid_q  <= 1'b0;
    end else begin
      cfg_shadow_q <= cfg_shadow_d;
      cfg_valid_q  <= frame_end;
      if (frame_end) cfg_out_q <= cfg_shadow_d;
    end
  end

  assign cfg_out   = cfg_out_q;
  assign cfg_valid = cfg_valid_q;
`else
  logic unused_sdi;
  assign unused_sdi = adc_sdi;
  assign cfg_out    = '0;
  assign cfg_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_adc_spi_responder.sv
// Self-checking bench for adc_spi_responder.
// The driver plays the ADC controller and pushes the expected frame when it issues a full frame.
// A monitor pops and compares whenever the DUT pulses frame_done, and also checks the busy width.
module tb_adc_spi_responder;

  localparam int DATA_W      = 12;
  localparam int CFG_W       = 6;
  localparam int CONV_CYCLES = 80;
`ifdef ADC_RESP_CFG_EN
  localparam bit CFG_EN = 1'b1;
`else
  localparam bit CFG_EN = 1'b0;
`endif

  logic              clk        = 1'b0;
  logic              reset      = 1'b0;
  logic              adc_convst = 1'b0;
  logic              adc_sck    = 1'b0;
  logic              adc_sdi    = 1'b0;
  logic [DATA_W-1:0] sample_in  = '0;
  logic              adc_sdo;
  logic              busy;
  logic [CFG_W-1:0]  cfg_out;
  logic              cfg_valid;
  logic              frame_done;

  always #5 clk = ~clk;

  adc_spi_responder #(
    .DATA_W      (DATA_W),
    .CFG_W       (CFG_W),
    .CONV_CYCLES (CONV_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .adc_convst (adc_convst),
    .adc_sck    (adc_sck),
    .adc_sdi    (adc_sdi),
    .adc_sdo    (adc_sdo),
    .sample_in  (sample_in),
    .busy       (busy),
    .cfg_out    (cfg_out),
    .cfg_valid  (cfg_valid),
    .frame_done (frame_done)
  );

  typedef struct {
    logic [DATA_W-1:0] sample;
    logic [CFG_W-1:0]  cfg;
  } frame_t;

  frame_t            exp_q[$];
  int                n_checks      = 0;
  int                n_pass        = 0;
  int                frames_issued = 0;
  int                fd_seen       = 0;
  int                cv_seen       = 0;
  logic [CFG_W-1:0]  model_cfg     = '0;
  logic [DATA_W-1:0] sdo_word      = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, req, $time);
  endtask

  // Controller view: sdo is sampled at every sck fall; the last DATA_W bits form the word.
  always @(negedge adc_sck) sdo_word = {sdo_word[DATA_W-2:0], adc_sdo};

  // Monitor: busy width, sdo quiet while busy, and frame/cfg scoreboard on frame_done.
  initial begin : monitor
    int     busy_len;
    bit     sdo_in_busy;
    bit     prev_fd;
    frame_t e;
    busy_len    = 0;
    sdo_in_busy = 1'b0;
    prev_fd     = 1'b0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        busy_len++;
        if (adc_sdo !== 1'b0) sdo_in_busy = 1'b1;
      end else if (busy_len != 0) begin
        check("busy_width", busy_len, CONV_CYCLES);
        check("sdo_zero_while_busy", sdo_in_busy, 0);
        busy_len    = 0;
        sdo_in_busy = 1'b0;
      end
      if (frame_done === 1'b1) begin
        fd_seen++;
        check("frame_done_one_cycle", prev_fd, 0);
        if (exp_q.size() == 0) begin
          check("frame_done_unexpected_queue_len", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("sdo_word", sdo_word, e.sample);
          check("cfg_out", cfg_out, CFG_EN ? e.cfg : '0);
        end
        check("cfg_valid_with_frame_done", cfg_valid, CFG_EN);
      end
      if (cfg_valid === 1'b1) begin
        cv_seen++;
        if (frame_done !== 1'b1) check("cfg_valid_without_frame_done", frame_done, 1);
      end
      prev_fd = (frame_done === 1'b1);
    end
  end

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  // convst pulse; busy must rise exactly 4 clk after the pin edge when a conversion starts.
  task automatic pulse_convst(input logic [DATA_W-1:0] smp, input bit check_latency);
    sample_in  = smp;
    adc_convst = 1'b1;
    clk_wait(3);
    if (check_latency) check("busy_low_before_4clk", busy, 0);
    clk_wait(1);
    check("busy_high_after_4clk", busy, 1);
    clk_wait(2);
    adc_convst = 1'b0;
  endtask

  // Bounded wait for the end of conversion; MSB must be on sdo as busy falls.
  task automatic wait_conv(input logic msb);
    int n;
    n = 0;
    while (busy !== 1'b1 && n < 10) begin clk_wait(1); n++; end
    while (busy === 1'b1 && n < CONV_CYCLES + 20) begin clk_wait(1); n++; end
    check("conversion_ends", busy, 0);
    check("msb_on_busy_fall", adc_sdo, msb);
  endtask

  task automatic sck_pulse(input logic b, input int hi, input int lo, input bit check_zero);
    adc_sdi = b;
    adc_sck = 1'b1;
    clk_wait(hi);
    adc_sck = 1'b0;
    if (check_zero) check("sdo_idle_at_fall", adc_sdo, 0);
    clk_wait(lo);
  endtask

  // One frame of nbits sck pulses; only complete frames have an expected response.
  task automatic run_frame(input logic [DATA_W-1:0] smp, input logic [CFG_W-1:0] cfg,
                           input int nbits, input bit extra_convst);
    int   hi;
    int   lo;
    logic b;
    hi = int'($urandom_range(4, 6));
    lo = int'($urandom_range(4, 6));
    pulse_convst(smp, 1'b1);
    if (extra_convst) begin
      clk_wait(10);
      pulse_convst(~smp, 1'b0);
    end
    wait_conv(smp[DATA_W-1]);
    if (nbits == DATA_W) begin
      exp_q.push_back('{sample: smp, cfg: cfg});
      frames_issued++;
      if (CFG_EN) model_cfg = cfg;
    end
    for (int i = 0; i < nbits; i++) begin
      b = (i < CFG_W) ? cfg[i] : 1'($urandom_range(0, 1));
      sck_pulse(b, hi, lo, 1'b0);
    end
    clk_wait(2);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int fd_before;

    // Reset state
    clk_wait(3);
    check("rst_sdo", adc_sdo, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_out", cfg_out, 0);
    check("rst_cfg_valid", cfg_valid, 0);
    check("rst_frame_done", frame_done, 0);
    reset = 1'b1;
    clk_wait(4);

    // Basic frame
    run_frame(12'hA5C, 6'b101101, DATA_W, 1'b0);
    check("cfg_after_basic", cfg_out, CFG_EN ? 6'b101101 : 6'b0);

    // Stray sck in IDLE
    fd_before = fd_seen;
    for (int i = 0; i < 10; i++) sck_pulse(1'($urandom_range(0, 1)), 4, 4, 1'b1);
    clk_wait(4);
    check("stray_busy", busy, 0);
    check("stray_no_frame_done", fd_seen, fd_before);

    // Abort after 5 bits, then a complete frame
    fd_before = fd_seen;
    run_frame(12'hFFF, 6'($urandom), 5, 1'b0);
    check("abort_cfg_held", cfg_out, model_cfg);
    check("abort_no_frame_done", fd_seen, fd_before);
    run_frame(12'h001, 6'($urandom), DATA_W, 1'b0);

    // convst during CONVERT is ignored
    run_frame(12'($urandom), 6'($urandom), DATA_W, 1'b1);

    // Mid-frame asynchronous reset after 7 bits
    run_frame(12'h0F0, 6'($urandom), 7, 1'b0);
    check("sdo_bit7_before_reset", adc_sdo, 1);
    #1 reset = 1'b0;
    #1;
    check("midrst_sdo", adc_sdo, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cfg_out", cfg_out, 0);
    check("midrst_cfg_valid", cfg_valid, 0);
    check("midrst_frame_done", frame_done, 0);
    model_cfg = '0;
    clk_wait(3);
    reset = 1'b1;
    clk_wait(3);
    run_frame(12'($urandom), 6'($urandom), DATA_W, 1'b0);

    // All-ones config word
    run_frame(12'h3C6, 6'b111111, DATA_W, 1'b0);
    check("cfg_all_ones", cfg_out, CFG_EN ? 6'b111111 : 6'b0);

    // Random frames
    for (int k = 0; k < 6; k++) run_frame(12'($urandom), 6'($urandom), DATA_W, 1'b0);
    check("cfg_model_final", cfg_out, model_cfg);

    // Totals
    clk_wait(10);
    check("frame_done_count", fd_seen, frames_issued);
    check("cfg_valid_count", cv_seen, CFG_EN ? frames_issued : 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
